// File: rtl/nodemem_arbiter_pkg.sv
// Shared definitions for the node-information memory arbiter:
// memory geometry, FSM state encoding and requester indices.
package nodemem_arbiter_pkg;

    localparam int MEM_DEPTH  = 2048;
    localparam int MEM_WIDTH  = 8;
    localparam int WORD_WIDTH = 16;

    // Requester slots on the req/gnt/ack vectors
    localparam int REQ_RX     = 0;
    localparam int REQ_BESTNB = 1;
    localparam int REQ_QUPD   = 2;

    // Word access sequencer: arbitrate, two byte cycles, capture, acknowledge
    typedef enum logic [2:0] {
        S_IDLE,
        S_B0,
        S_B1,
        S_CAP,
        S_ACK
    } state_t;

endpackage

// File: rtl/nodemem_arbiter_rr_arbiter.sv
// One-hot winner selection for the node-memory arbiter.
// Default: round-robin, searching upward from (last winner + 1) mod NREQ.
// With NODEMEM_FIXED_PRIO_EN defined: fixed priority, req[0] highest, so the
// RX table writer can never be starved; the pointer input is then ignored.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] last,
    output logic [NREQ-1:0]  winner
);

    logic found;

`ifdef NODEMEM_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last;

    // Lowest-index requester wins
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end
`else
    // First requester at or after last+1, wrapping modulo NREQ
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(last) + k) % NREQ]) begin
                winner[(int'(last) + k) % NREQ] = 1'b1;
                found                            = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/nodemem_arbiter.sv
// Node-information memory arbiter. Three engines share one byte-wide
// synchronous RAM; each 16-bit word access is serialised as two byte cycles
// (big-endian: high byte at A, low byte at A+1, wrapping at the top).
// Build option: NODEMEM_FIXED_PRIO_EN selects fixed priority instead of
// round-robin; timing and ports are identical in both builds.
module nodemem_arbiter
    import nodemem_arbiter_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = $clog2(MEM_DEPTH),
    parameter int WORD_W = WORD_WIDTH,
    parameter int MEM_W  = MEM_WIDTH
) (
    input  logic                   clock,
    input  logic                   nrst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*WORD_W-1:0] wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        ack,
    output logic [WORD_W-1:0]      rdata,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [MEM_W-1:0]       mem_wdata,
    output logic                   mem_wr_en,
    input  logic [MEM_W-1:0]       mem_rdata
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t             state;
    logic [PTR_W-1:0]   last;
    logic [NREQ-1:0]    win;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   gnt_idx;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  addr_lo;
    logic [WORD_W-1:0]  wdata_q;
    logic [MEM_W-1:0]   hi_q;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req    (req),
        .last   (last),
        .winner (win)
    );

    // Index of the arbitration winner, used to pick its request fields
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (win[i]) win_idx = PTR_W'(i);
    end

    // Index of the current grant, becomes the new round-robin pointer
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) gnt_idx = PTR_W'(i);
    end

    // Low byte address; wraps naturally at the top of the byte space
    assign addr_lo = addr_q + ADDR_W'(1);

    // Access sequencer with registered gnt/ack/rdata. The high read byte is
    // parked in hi_q so rdata changes only once, when a read completes.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            state   <= S_IDLE;
            gnt     <= '0;
            ack     <= '0;
            rdata   <= '0;
            last    <= PTR_W'(NREQ - 1);
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hi_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        gnt     <= win;
                        we_q    <= we[win_idx];
                        addr_q  <= addr[win_idx*ADDR_W +: ADDR_W];
                        wdata_q <= wdata[win_idx*WORD_W +: WORD_W];
                        state   <= S_B0;
                    end
                end
                S_B0: begin
                    state <= S_B1;
                end
                S_B1: begin
                    if (!we_q) hi_q <= mem_rdata;
                    state <= S_CAP;
                end
                S_CAP: begin
                    if (!we_q) rdata <= {hi_q, mem_rdata};
                    ack   <= gnt;
                    state <= S_ACK;
                end
                S_ACK: begin
                    ack   <= '0;
                    gnt   <= '0;
                    last  <= gnt_idx;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory port decoded from the state and the latched request
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr_en = 1'b0;
        case (state)
            S_B0: begin
                mem_addr = addr_q;
                if (we_q) begin
                    mem_wdata = wdata_q[WORD_W-1 -: MEM_W];
                    mem_wr_en = 1'b1;
                end
            end
            S_B1: begin
                mem_addr = addr_lo;
                if (we_q) begin
                    mem_wdata = wdata_q[MEM_W-1:0];
                    mem_wr_en = 1'b1;
                end
            end
            S_CAP: begin
                mem_addr = addr_lo;
            end
            default: ;
        endcase
    end

endmodule
